// File: rtl/ppi_seq_ctrl.sv
// Sequencer for a serial single-MAC polyphase interpolator: one buffered sample, 1 + L*taps cycles per frame.
// Latency: registered outputs (o_out_stb one cycle after a phase's last tap); backpressure via o_ready = ~pending.
module ppi_seq_ctrl #(
    parameter int gp_inp_width = 16,
    parameter int gp_max_l     = 4,
    parameter int gp_taps      = 8,
    parameter int gp_l_w       = 3,
    localparam int lp_tap_w    = $clog2(gp_taps),
    localparam int lp_ph_w     = (gp_max_l > 1) ? $clog2(gp_max_l) : 1,
    localparam int lp_ca_w     = $clog2(gp_max_l * gp_taps)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_an,
    input  logic                    i_ena,
    input  logic [gp_l_w-1:0]       i_l,
    input  logic                    i_valid,
    input  logic [gp_inp_width-1:0] i_data,
    output logic                    o_ready,
    output logic                    o_dly_we,
    output logic [gp_inp_width-1:0] o_dly_data,
    output logic [lp_tap_w-1:0]     o_dly_addr,
    output logic [lp_ca_w-1:0]      o_coef_addr,
    output logic [lp_ph_w-1:0]      o_phase,
    output logic                    o_mac_clr,
    output logic                    o_mac_en,
    output logic                    o_out_stb,
    output logic                    o_busy,
    output logic                    o_underrun
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_MAC} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_pend, r_run;
    logic [gp_inp_width-1:0] r_hold, r_dly_data, w_hold_nxt;
    logic [lp_tap_w-1:0]     r_tap, w_tap_nxt;
    logic [lp_ph_w-1:0]      r_phase, w_phase_nxt;
    logic [gp_l_w-1:0]       r_l, w_l_nxt, w_l_clamp;
    logic [lp_ca_w-1:0]      r_coef;
    logic                    r_dly_we, r_mac_en, r_mac_clr, r_out_stb, r_undr, r_busy;
    logic                    w_fire, w_pend_nxt, w_tap_end, w_ph_end, w_stb, w_undr;

    // r_run keeps o_ready low until the first clock after reset release
    assign o_ready    = i_ena & r_run & ~r_pend;
    assign w_fire     = i_valid & o_ready;
    assign w_pend_nxt = ((r_state == ST_LOAD) ? 1'b0 : r_pend) | w_fire;
    assign w_hold_nxt = w_fire ? i_data : r_hold;
    assign w_tap_end  = (r_tap == lp_tap_w'(gp_taps - 1));
    assign w_ph_end   = ((32'(r_phase) + 32'd1) == 32'(r_l));

    always_comb begin
        w_l_clamp = i_l;
        if (i_l == '0)
            w_l_clamp = gp_l_w'(1);
        else if (int'(i_l) > gp_max_l)
            w_l_clamp = gp_l_w'(gp_max_l);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tap_nxt   = r_tap;
        w_phase_nxt = r_phase;
        w_l_nxt     = r_l;
        w_stb       = 1'b0;
        w_undr      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_pend) begin
                    w_state_nxt = ST_LOAD;
                    w_l_nxt     = w_l_clamp;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_MAC;
                w_tap_nxt   = '0;
                w_phase_nxt = '0;
            end
            ST_MAC: begin
                if (w_tap_end) begin
                    w_tap_nxt = '0;
                    w_stb     = 1'b1;
                    if (w_ph_end) begin
                        // a sample accepted this very cycle chains straight into the next frame
                        w_phase_nxt = '0;
                        if (w_pend_nxt) begin
                            w_state_nxt = ST_LOAD;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_undr      = ~i_valid;
                        end
                    end else begin
                        w_phase_nxt = r_phase + lp_ph_w'(1);
                    end
                end else begin
                    w_tap_nxt = r_tap + lp_tap_w'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an)
            r_state <= ST_IDLE;
        else if (i_ena)
            r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            r_run      <= 1'b0;
            r_pend     <= 1'b0;
            r_hold     <= '0;
            r_tap      <= '0;
            r_phase    <= '0;
            r_l        <= gp_l_w'(1);
            r_coef     <= '0;
            r_dly_we   <= 1'b0;
            r_dly_data <= '0;
            r_mac_en   <= 1'b0;
            r_mac_clr  <= 1'b0;
            r_out_stb  <= 1'b0;
            r_undr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (i_ena) begin
                r_pend    <= w_pend_nxt;
                r_hold    <= w_hold_nxt;
                r_tap     <= w_tap_nxt;
                r_phase   <= w_phase_nxt;
                r_l       <= w_l_nxt;
                r_coef    <= lp_ca_w'(32'(w_phase_nxt) * gp_taps + 32'(w_tap_nxt));
                r_dly_we  <= (w_state_nxt == ST_LOAD);
                if (w_state_nxt == ST_LOAD)
                    r_dly_data <= w_hold_nxt;
                r_mac_en  <= (w_state_nxt == ST_MAC);
                r_mac_clr <= (w_state_nxt == ST_MAC) && (w_tap_nxt == '0);
                r_out_stb <= w_stb;
                r_undr    <= w_undr;
                r_busy    <= (w_state_nxt != ST_IDLE);
            end
        end
    end

    // strobes are gated so a frozen cycle never looks like a MAC step to the datapath
    assign o_dly_we    = r_dly_we & i_ena;
    assign o_mac_en    = r_mac_en & i_ena;
    assign o_mac_clr   = r_mac_clr & i_ena;
    assign o_out_stb   = r_out_stb & i_ena;
    assign o_underrun  = r_undr & i_ena;
    assign o_dly_data  = r_dly_data;
    assign o_dly_addr  = r_tap;
    assign o_coef_addr = r_coef;
    assign o_phase     = r_phase;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_ppi_seq_ctrl.sv
// Directed bench for ppi_seq_ctrl: reset, single frames, streaming, enable freeze, L clamping, mid-frame reset.
module tb_ppi_seq_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_an = 1'b1;
    logic        i_ena = 1'b1;
    logic [2:0]  i_l = 3'd1;
    logic        i_valid = 1'b0;
    logic [15:0] i_data = '0;
    logic        o_ready, o_dly_we, o_mac_clr, o_mac_en, o_out_stb, o_busy, o_underrun;
    logic [15:0] o_dly_data;
    logic [2:0]  o_dly_addr;
    logic [4:0]  o_coef_addr;
    logic [1:0]  o_phase;

    int n_checks = 0;
    int n_err = 0;

    ppi_seq_ctrl dut (
        .i_clk(i_clk), .i_rst_an(i_rst_an), .i_ena(i_ena), .i_l(i_l),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
        .o_dly_we(o_dly_we), .o_dly_data(o_dly_data), .o_dly_addr(o_dly_addr),
        .o_coef_addr(o_coef_addr), .o_phase(o_phase), .o_mac_clr(o_mac_clr),
        .o_mac_en(o_mac_en), .o_out_stb(o_out_stb), .o_busy(o_busy),
        .o_underrun(o_underrun)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // sends one sample with the given L and runs until the sequencer is idle again
    task automatic run_frame(input logic [2:0] l, input logic [15:0] d,
                             output int macs, output int stbs, output int undr, output int done);
        int seen;
        macs = 0; stbs = 0; undr = 0; done = 0; seen = 0;
        i_l = l; i_data = d; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tick();
            macs += int'(o_mac_en);
            stbs += int'(o_out_stb);
            undr += int'(o_underrun);
            if (o_busy) seen = 1;
            else if (seen != 0) begin done = 1; break; end
        end
    endtask

    initial begin
        int macs, stbs, undr, done, seen, frozen, wes, last_we, fired;
        logic [15:0] exp_d;

        // 1: reset
        #1 i_rst_an = 1'b0;
        tick(); tick();
        chk("rst_data", 32'(o_dly_data), 0);
        chk("rst_ctrl", {o_ready, o_dly_we, o_dly_addr, o_coef_addr, o_phase,
                         o_mac_clr, o_mac_en, o_out_stb, o_busy, o_underrun}, 0);
        i_rst_an = 1'b1;
        #1 chk("rel_ready_before_clk", 32'(o_ready), 0);
        tick();
        chk("rel_ready", 32'(o_ready), 1);
        chk("rel_busy", 32'(o_busy), 0);

        // 2: single sample, L=2
        i_l = 3'd2; i_data = 16'h1234; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("t2_pend_ready", 32'(o_ready), 0);
        tick();
        chk("t2_we", 32'(o_dly_we), 1);
        chk("t2_data", 32'(o_dly_data), 32'h1234);
        chk("t2_busy", 32'(o_busy), 1);
        chk("t2_load_mac", 32'(o_mac_en), 0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("t2_en%0d", k), 32'(o_mac_en), 1);
            chk($sformatf("t2_coef%0d", k), 32'(o_coef_addr), k);
            chk($sformatf("t2_tap%0d", k), 32'(o_dly_addr), k % 8);
            chk($sformatf("t2_ph%0d", k), 32'(o_phase), k / 8);
            chk($sformatf("t2_clr%0d", k), 32'(o_mac_clr), (k % 8 == 0) ? 1 : 0);
            chk($sformatf("t2_stb%0d", k), 32'(o_out_stb), (k == 8) ? 1 : 0);
            chk($sformatf("t2_we%0d", k), 32'(o_dly_we), 0);
        end
        tick();
        chk("t2_end_stb", 32'(o_out_stb), 1);
        chk("t2_end_undr", 32'(o_underrun), 1);
        chk("t2_end_busy", 32'(o_busy), 0);
        chk("t2_end_en", 32'(o_mac_en), 0);
        tick();
        chk("t2_undr_pulse", 32'(o_underrun), 0);
        chk("t2_stb_pulse", 32'(o_out_stb), 0);

        // 3: streaming ramp with L=4
        i_l = 3'd4; i_data = 16'h0100; i_valid = 1'b1;
        exp_d = 16'h0100; last_we = -1; macs = 0; stbs = 0; undr = 0;
        for (int c = 0; c < 140; c++) begin
            fired = int'(o_ready);
            tick();
            if (fired != 0) begin
                i_data = i_data + 16'd1;
                chk("t3_pend_ready", 32'(o_ready), 0);
            end
            undr += int'(o_underrun);
            stbs += int'(o_out_stb);
            macs += int'(o_mac_en);
            if (o_dly_we) begin
                chk("t3_data", 32'(o_dly_data), 32'(exp_d));
                exp_d = exp_d + 16'd1;
                if (last_we >= 0) begin
                    chk("t3_period", c - last_we, 33);
                    chk("t3_stbs", stbs, 4);
                    chk("t3_macs", macs, 32);
                end
                last_we = c; stbs = 0; macs = 0;
            end
        end
        chk("t3_undr", undr, 0);
        chk("t3_frames", 32'(exp_d), 32'h0105);
        i_valid = 1'b0;
        done = 0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (!o_busy) begin done = 1; break; end
        end
        chk("t3_drain", done, 1);
        tick();

        // 4: enable freeze at coefficient address 11
        i_l = 3'd4; i_data = 16'h4444; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        macs = 0; stbs = 0; seen = 0; frozen = 0; done = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (frozen == 0 && o_mac_en && o_coef_addr == 5'd11) begin
                frozen = 1;
                i_ena = 1'b0;
                #1;
                for (int f = 0; f < 5; f++) begin
                    if (f > 0) tick();
                    chk("t4_frz_addr", 32'(o_coef_addr), 11);
                    chk("t4_frz_strobes", {o_mac_en, o_mac_clr, o_out_stb, o_dly_we,
                                           o_underrun, o_ready}, 0);
                end
                i_ena = 1'b1;
                #1;
                chk("t4_resume_addr", 32'(o_coef_addr), 11);
                chk("t4_resume_tap", {o_phase, o_dly_addr}, {2'd1, 3'd3});
                chk("t4_resume_en", 32'(o_mac_en), 1);
            end
            macs += int'(o_mac_en);
            stbs += int'(o_out_stb);
            if (o_busy) seen = 1;
            else if (seen != 0) begin done = 1; break; end
        end
        chk("t4_done", done, 1);
        chk("t4_frozen", frozen, 1);
        chk("t4_macs", macs, 32);
        chk("t4_stbs", stbs, 4);
        tick();

        // 5: L clamping and mid-stream L change
        run_frame(3'd0, 16'h0A0A, macs, stbs, undr, done);
        chk("t5_l0_done", done, 1);
        chk("t5_l0_macs", macs, 8);
        chk("t5_l0_stbs", stbs, 1);
        chk("t5_l0_undr", undr, 1);
        tick();
        run_frame(3'd7, 16'h0B0B, macs, stbs, undr, done);
        chk("t5_l7_done", done, 1);
        chk("t5_l7_macs", macs, 32);
        chk("t5_l7_stbs", stbs, 4);
        tick();
        i_l = 3'd4; i_data = 16'h5000; i_valid = 1'b1;
        wes = 0; macs = 0; done = 0;
        for (int c = 0; c < 200; c++) begin
            fired = int'(o_ready & i_valid);
            tick();
            if (fired != 0) i_data = i_data + 16'd1;
            if (o_dly_we) begin
                wes++;
                if (wes == 1) i_l = 3'd2;
                if (wes == 2) begin
                    i_valid = 1'b0;
                    chk("t5_mid_f1_macs", macs, 32);
                end
                macs = 0;
            end
            macs += int'(o_mac_en);
            if (wes >= 2 && !o_busy) begin done = 1; break; end
        end
        chk("t5_mid_done", done, 1);
        chk("t5_mid_f2_macs", macs, 32);
        tick();
        run_frame(3'd2, 16'h0C0C, macs, stbs, undr, done);
        chk("t5_l2_done", done, 1);
        chk("t5_l2_macs", macs, 16);
        tick();

        // 6: reset mid-frame with a sample pending
        i_l = 3'd4; i_data = 16'hBEEF; i_valid = 1'b1;
        done = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (o_mac_en && o_phase == 2'd1 && o_dly_addr == 3'd3) begin done = 1; break; end
        end
        chk("t6_found", done, 1);
        chk("t6_pending", 32'(o_ready), 0);
        i_rst_an = 1'b0;
        #1;
        chk("t6_rst_data", 32'(o_dly_data), 0);
        chk("t6_rst_ctrl", {o_ready, o_dly_we, o_dly_addr, o_coef_addr, o_phase,
                            o_mac_clr, o_mac_en, o_out_stb, o_busy, o_underrun}, 0);
        i_valid = 1'b0;
        tick(); tick();
        i_rst_an = 1'b1;
        tick();
        chk("t6_ready", 32'(o_ready), 1);
        chk("t6_busy", 32'(o_busy), 0);
        wes = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            wes += int'(o_dly_we) + int'(o_busy);
        end
        chk("t6_no_load", wes, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ppi_seq_ctrl.md
Name: ppi_seq_ctrl

Overview:
Sequencer for a serial, single-MAC polyphase interpolator (ppi datapath). It accepts input samples over a valid/ready handshake and buffers one sample. For each sample it loads the delay line, then walks L phases x gp_taps taps, generating coefficient and delay-line addresses and MAC clear/enable controls. It emits one output strobe per phase. It runs on the single system clock with clock-enable timing and does not derive a slow clock.

Parameters:
gp_inp_width, 16, input sample width
gp_max_l, 4, maximum interpolation factor (>=1)
gp_taps, 8, taps per polyphase branch (>=2)
gp_l_w, 3, width of i_l (must hold gp_max_l)

Ports:
i_clk  in  1  system clock
i_rst_an  in  1  asynchronous active-low reset
i_ena  in  1  global enable; low freezes all state
i_l  in  gp_l_w  interpolation factor request
i_valid  in  1  input sample valid
i_data  in  gp_inp_width  input sample
o_ready  out  1  holding register free
o_dly_we  out  1  shift o_dly_data into delay line
o_dly_data  out  gp_inp_width  sample to delay line
o_dly_addr  out  clog2(gp_taps)  delay-line tap read address
o_coef_addr  out  clog2(gp_max_l*gp_taps)  coefficient ROM address
o_phase  out  clog2(gp_max_l)  current phase
o_mac_clr  out  1  load (not accumulate) product this cycle
o_mac_en  out  1  MAC active this cycle
o_out_stb  out  1  accumulator holds finished phase output
o_busy  out  1  state != IDLE
o_underrun  out  1  one-cycle pulse: frame ended with no sample pending

Behaviour:
- Reset, asynchronous: every output is 0, state is IDLE, pending=0, phase=0, tap=0, r_l=1. o_ready is 1 from the first clock after release, provided i_ena=1.
- Holding register:
  - o_ready = i_ena & ~pending, driven combinationally from registered pending.
  - Handshake fires when i_valid & o_ready. On a fire, i_data is latched and pending is set.
- States IDLE, LOAD, MAC:
  - IDLE: when pending=1, latch r_l and go to LOAD. r_l = 1 if i_l=0; r_l = gp_max_l if i_l>gp_max_l; otherwise r_l = i_l.
  - LOAD (1 cycle): o_dly_we=1, o_dly_data=held sample, pending cleared (a same-cycle handshake may set it again), phase=0, tap=0. Next state is MAC.
  - MAC: each cycle drives o_mac_en=1, o_dly_addr=tap, o_coef_addr=phase*gp_taps+tap, o_phase=phase, o_mac_clr=(tap==0). tap increments each cycle.
  - When tap==gp_taps-1: tap wraps to 0 and phase increments.
  - At the last tap of phase r_l-1, the next state is evaluated using next-cycle pending, so a sample accepted in that same cycle counts:
    - pending=1: go to LOAD. r_l is kept; it is not re-sampled.
    - pending=0: go to IDLE and pulse o_underrun for 1 cycle, only if i_valid was low.
- o_out_stb: registered, asserted the cycle after each last-tap cycle, i.e. 1-cycle latency, aligned with the accumulator register. There is exactly one pulse per phase.
- Throughput: 1 + r_l*gp_taps cycles per input sample. Output strobes within a frame are spaced exactly gp_taps cycles apart.
- All outputs are registered except o_ready.
- i_ena=0: state, counters, pending and r_l hold. o_dly_we, o_mac_en, o_mac_clr, o_out_stb, o_underrun and o_ready are forced to 0. Addresses hold their values. When i_ena returns high, operation resumes at the same tap/phase with no lost or repeated tap.
- i_l changes during a frame or between back-to-back frames are ignored. i_l is only sampled on IDLE->LOAD.
- Reset asserted mid-frame: immediate return to the reset values above. The pending sample is discarded.

Test Plan:
1. Hold i_rst_an=0 -> all outputs 0. Release with i_ena=1 -> o_ready=1, o_busy=0 after 1 clock.
2. i_l=2, one i_valid pulse with data 0x1234 -> o_dly_we for 1 cycle with o_dly_data=0x1234. Then 16 o_mac_en cycles with o_coef_addr 0..15, o_mac_clr at addr 0 and 8, o_out_stb one cycle after addr 7 and addr 15. Then o_underrun pulse and o_busy=0.
3. i_l=4, i_valid held high with an incrementing ramp -> one o_dly_we every 33 cycles with o_dly_data in sequence, 4 o_out_stb per frame 8 cycles apart, no o_underrun, o_ready low while pending.
4. Drop i_ena for 5 cycles at o_coef_addr=11 -> addresses frozen at 11, strobes 0. Resumes at 11; total o_mac_en count per frame stays 32.
5. i_l=0 -> 8 MAC cycles per frame. i_l=7 -> clamped to 4 (32 cycles). Change i_l 4->2 mid-stream -> frame length unchanged until an IDLE visit.
6. Assert i_rst_an=0 at phase 1, tap 3, with a sample pending -> outputs 0 immediately. After release: IDLE, o_ready=1, no o_dly_we.
